// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : timer_pkg                                              |
// | Description : Shared field widths, wrap limits and channel state     |
// |               encoding for the multi_timer countdown channels.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package timer_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_channel                                          |
// | Description : One HH:MM:SS countdown channel with reload register,   |
// |               IDLE/RUN/PAUSED/DONE control and sticky done flag.     |
// |               Optional auto-reload at expiry: TIMER_AUTORELOAD_EN.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_channel
  import timer_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              set_mode_i,
  input  logic              inc_hours_i,
  input  logic              inc_minutes_i,
  input  logic              inc_seconds_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
`ifdef TIMER_AUTORELOAD_EN
  input  logic              autoreload_i,
`endif
  output logic [HOUR_W-1:0] hours_o,
  output logic [MIN_W-1:0]  minutes_o,
  output logic [SEC_W-1:0]  seconds_o,
  output logic              running_o,
  output logic              done_o,
  output logic              done_pulse_o
);

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] hours_q, hours_d, rl_hours_q, rl_hours_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d, rl_minutes_q, rl_minutes_d;
  logic [SEC_W-1:0]  seconds_q, seconds_d, rl_seconds_q, rl_seconds_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;
`ifdef TIMER_AUTORELOAD_EN
  logic              ar_q, ar_d;
`endif

  logic w_cmd_clear, w_cmd_stop, w_cmd_start, w_cmd_inc;
  logic w_tick, w_count_zero, w_count_one;

  // Only the highest-priority asserted command is considered; the rest are dropped.
  assign w_cmd_clear  = sel_i & clear_i;
  assign w_cmd_stop   = sel_i & ~clear_i & stop_i;
  assign w_cmd_start  = sel_i & ~clear_i & ~stop_i & start_i;
  assign w_cmd_inc    = sel_i & ~clear_i & ~stop_i & ~start_i & set_mode_i &
                        (inc_hours_i | inc_minutes_i | inc_seconds_i);
  // A running channel counts unless this edge clears or pauses it.
  assign w_tick       = (state_q == ST_RUN) & ~w_cmd_clear & ~w_cmd_stop;
  assign w_count_zero = (hours_q == '0) && (minutes_q == '0) && (seconds_q == '0);
  assign w_count_one  = (hours_q == '0) && (minutes_q == '0) && (seconds_q == SEC_W'(1));

  // State register for count, reload value, control state and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      hours_q      <= '0;
      minutes_q    <= '0;
      seconds_q    <= '0;
      rl_hours_q   <= '0;
      rl_minutes_q <= '0;
      rl_seconds_q <= '0;
      done_q       <= 1'b0;
      pulse_q      <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      ar_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      rl_hours_q   <= rl_hours_d;
      rl_minutes_q <= rl_minutes_d;
      rl_seconds_q <= rl_seconds_d;
      done_q       <= done_d;
      pulse_q      <= pulse_d;
`ifdef TIMER_AUTORELOAD_EN
      ar_q         <= ar_d;
`endif
    end
  end

  // Next-state: command decode followed by the per-second borrow countdown.
  always_comb begin
    state_d      = state_q;
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    rl_hours_d   = rl_hours_q;
    rl_minutes_d = rl_minutes_q;
    rl_seconds_d = rl_seconds_q;
    done_d       = done_q;
    pulse_d      = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    ar_d         = ar_q;
`endif

    if (w_cmd_clear) begin
      state_d      = ST_IDLE;
      hours_d      = '0;
      minutes_d    = '0;
      seconds_d    = '0;
      rl_hours_d   = '0;
      rl_minutes_d = '0;
      rl_seconds_d = '0;
      done_d       = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      ar_d         = 1'b0;
`endif
    end else if (w_cmd_stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (w_cmd_start && (state_q != ST_RUN)) begin
      if (state_q == ST_PAUSED) begin
        state_d = ST_RUN;
      end else if (!w_count_zero && !set_mode_i) begin
        state_d      = ST_RUN;
        rl_hours_d   = hours_q;
        rl_minutes_d = minutes_q;
        rl_seconds_d = seconds_q;
`ifdef TIMER_AUTORELOAD_EN
        ar_d         = autoreload_i;
`endif
      end
    end else if (w_cmd_inc && (state_q != ST_RUN)) begin
      if (inc_hours_i)
        hours_d = (hours_q == HOUR_W'(HOUR_MAX)) ? '0 : hours_q + HOUR_W'(1);
      if (inc_minutes_i)
        minutes_d = (minutes_q == MIN_W'(MIN_MAX)) ? '0 : minutes_q + MIN_W'(1);
      if (inc_seconds_i)
        seconds_d = (seconds_q == SEC_W'(SEC_MAX)) ? '0 : seconds_q + SEC_W'(1);
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    end else if (w_tick) begin
      if (w_count_one) begin
        pulse_d = 1'b1;
        done_d  = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
        if (ar_q) begin
          hours_d   = rl_hours_q;
          minutes_d = rl_minutes_q;
          seconds_d = rl_seconds_q;
        end else begin
          seconds_d = '0;
          state_d   = ST_DONE;
        end
`else
        seconds_d = '0;
        state_d   = ST_DONE;
`endif
      end else if (seconds_q != '0) begin
        seconds_d = seconds_q - SEC_W'(1);
      end else begin
        seconds_d = SEC_W'(SEC_MAX);
        if (minutes_q != '0) begin
          minutes_d = minutes_q - MIN_W'(1);
        end else begin
          minutes_d = MIN_W'(MIN_MAX);
          hours_d   = hours_q - HOUR_W'(1);
        end
      end
    end
  end

  assign hours_o      = hours_q;
  assign minutes_o    = minutes_q;
  assign seconds_o    = seconds_q;
  assign running_o    = (state_q == ST_RUN);
  assign done_o       = done_q;
  assign done_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multi_timer                                            |
// | Description : N_CH independent HH:MM:SS countdown timers on a 1 Hz   |
// |               clock, addressed through ch_sel, with per-channel      |
// |               status and a combinational readback mux.               |
// |               Optional feature macro: TIMER_AUTORELOAD_EN.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int HOUR_MAX = 23
) (
  input  logic                                     clk_1Hz,
  input  logic                                     reset,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  input  logic                                     set_mode,
  input  logic                                     inc_hours,
  input  logic                                     inc_minutes,
  input  logic                                     inc_seconds,
  input  logic                                     start,
  input  logic                                     stop,
  input  logic                                     clear,
  input  logic                                     autoreload,
  output logic [4:0]                               sel_hours,
  output logic [5:0]                               sel_minutes,
  output logic [5:0]                               sel_seconds,
  output logic [N_CH-1:0]                          running,
  output logic [N_CH-1:0]                          done,
  output logic [N_CH-1:0]                          done_pulse,
  output logic                                     any_done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [HOUR_W-1:0] w_hours   [N_CH];
  logic [MIN_W-1:0]  w_minutes [N_CH];
  logic [SEC_W-1:0]  w_seconds [N_CH];

`ifndef TIMER_AUTORELOAD_EN
  // The auto-reload request has no effect when the feature is not built.
  logic w_unused_autoreload;
  assign w_unused_autoreload = autoreload;
`endif

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      timer_channel #(
        .HOUR_MAX (HOUR_MAX)
      ) u_ch (
        .clk_i         (clk_1Hz),
        .rst_i         (reset),
        .sel_i         (ch_sel == CH_W'(gi)),
        .set_mode_i    (set_mode),
        .inc_hours_i   (inc_hours),
        .inc_minutes_i (inc_minutes),
        .inc_seconds_i (inc_seconds),
        .start_i       (start),
        .stop_i        (stop),
        .clear_i       (clear),
`ifdef TIMER_AUTORELOAD_EN
        .autoreload_i  (autoreload),
`endif
        .hours_o       (w_hours[gi]),
        .minutes_o     (w_minutes[gi]),
        .seconds_o     (w_seconds[gi]),
        .running_o     (running[gi]),
        .done_o        (done[gi]),
        .done_pulse_o  (done_pulse[gi])
      );
    end
  endgenerate

  // Zero-latency readback of the addressed channel; out-of-range selects read zero.
  always_comb begin
    sel_hours   = '0;
    sel_minutes = '0;
    sel_seconds = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        sel_hours   = w_hours[i];
        sel_minutes = w_minutes[i];
        sel_seconds = w_seconds[i];
      end
    end
  end

  assign any_done = |done;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_multi_timer                                         |
// | Description : Directed self-checking bench for multi_timer (N_CH=4,  |
// |               HOUR_MAX=23). Auto-reload scenario selected by         |
// |               TIMER_AUTORELOAD_EN.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_multi_timer;

  logic       clk_1Hz = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] ch_sel  = '0;
  logic       set_mode = 1'b0;
  logic       inc_hours = 1'b0, inc_minutes = 1'b0, inc_seconds = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic       autoreload = 1'b0;
  logic [4:0] sel_hours;
  logic [5:0] sel_minutes, sel_seconds;
  logic [3:0] running, done, done_pulse;
  logic       any_done;

  int checks   = 0;
  int failures = 0;

  multi_timer #(
    .N_CH     (4),
    .HOUR_MAX (23)
  ) dut (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .ch_sel      (ch_sel),
    .set_mode    (set_mode),
    .inc_hours   (inc_hours),
    .inc_minutes (inc_minutes),
    .inc_seconds (inc_seconds),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .autoreload  (autoreload),
    .sel_hours   (sel_hours),
    .sel_minutes (sel_minutes),
    .sel_seconds (sel_seconds),
    .running     (running),
    .done        (done),
    .done_pulse  (done_pulse),
    .any_done    (any_done)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 2 time units past it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1Hz);
      #2;
    end
  endtask

  // which: 0=hours 1=minutes 2=seconds
  task automatic inc_field(input logic [1:0] ch, input int which, input int n);
    ch_sel   = ch;
    set_mode = 1'b1;
    inc_hours   = (which == 0);
    inc_minutes = (which == 1);
    inc_seconds = (which == 2);
    step(n);
    set_mode = 1'b0;
    inc_hours = 1'b0; inc_minutes = 1'b0; inc_seconds = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] ch);
    ch_sel = ch; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear(input logic [1:0] ch);
    ch_sel = ch; clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic check_hms(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, 32'(sel_hours),   32'(h));
    check({tag, "_m"}, 32'(sel_minutes), 32'(m));
    check({tag, "_s"}, 32'(sel_seconds), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check_hms("rst", 0, 0, 0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pulse", 32'(done_pulse), 32'h0);
    check("rst_any", 32'(any_done), 32'h0);
    step(2);
    reset = 1'b0;

    // Channel 1: 00:00:05 countdown
    inc_field(2'd1, 2, 5);
    check_hms("c1_set", 0, 0, 5);
    pulse_start(2'd1);
    check("c1_run", 32'(running), 32'h2);
    check("c1_startedge_s", 32'(sel_seconds), 32'd5);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("c1_cnt_s", 32'(sel_seconds), 32'(5 - k));
      check("c1_nopulse", 32'(done_pulse), 32'h0);
    end
    step(1);
    check("c1_pulse", 32'(done_pulse), 32'h2);
    check("c1_done", 32'(done), 32'h2);
    check("c1_stopped", 32'(running), 32'h0);
    check("c1_any", 32'(any_done), 32'h1);
    step(1);
    check("c1_pulse_end", 32'(done_pulse), 32'h0);
    check("c1_done_sticky", 32'(done), 32'h2);

    // Channel 0: 01:00:00, borrow, pause and resume
    inc_field(2'd0, 0, 1);
    check_hms("c0_set", 1, 0, 0);
    pulse_start(2'd0);
    step(1);
    check_hms("c0_borrow", 0, 59, 59);
    stop = 1'b1; step(1); stop = 1'b0;
    check("c0_paused", 32'(running), 32'h0);
    step(2);
    check_hms("c0_held", 0, 59, 59);
    pulse_start(2'd0);
    check("c0_resumed", 32'(running), 32'h1);
    check_hms("c0_resume_edge", 0, 59, 59);
    step(1);
    check_hms("c0_resumed_cnt", 0, 59, 58);
    pulse_clear(2'd0);
    check_hms("c0_cleared", 0, 0, 0);
    check("c0_clr_run", 32'(running), 32'h0);

    // Field wrap on channel 2
    inc_field(2'd2, 0, 23);
    check("c2_h23", 32'(sel_hours), 32'd23);
    inc_field(2'd2, 0, 1);
    check("c2_hwrap", 32'(sel_hours), 32'd0);
    inc_field(2'd2, 1, 60);
    check("c2_mwrap", 32'(sel_minutes), 32'd0);

    // inc_seconds during RUN is ignored
    inc_field(2'd0, 2, 10);
    pulse_start(2'd0);
    step(1);
    check("c0_run9", 32'(sel_seconds), 32'd9);
    set_mode = 1'b1; inc_seconds = 1'b1; step(1);
    set_mode = 1'b0; inc_seconds = 1'b0;
    check("c0_inc_in_run", 32'(sel_seconds), 32'd8);
    pulse_clear(2'd0);

    // Channels 2 and 3 concurrently, clear ch 3 mid-run
    inc_field(2'd3, 2, 6);
    inc_field(2'd2, 2, 3);
    pulse_start(2'd3);
    pulse_start(2'd2);
    step(1);
    check("c23_run", 32'(running), 32'hC);
    pulse_clear(2'd3);
    check("c3_clr_run", 32'(running), 32'h4);
    check_hms("c3_clr", 0, 0, 0);
    ch_sel = 2'd2; #1;
    check("mux_zero_lat", 32'(sel_seconds), 32'd1);
    step(1);
    check("c2_pulse", 32'(done_pulse), 32'h4);
    check("c2_done", 32'(done), 32'h6);
    check("c2_any", 32'(any_done), 32'h1);
    check_hms("c2_zero", 0, 0, 0);

    // Start with a zero count is ignored
    pulse_start(2'd3);
    check("c3_zero_start", 32'(running), 32'h0);

    // Accepted inc moves DONE to IDLE and clears done
    inc_field(2'd1, 2, 1);
    check("c1_done_clr", 32'(done), 32'h4);

    // Asynchronous reset mid-run
    inc_field(2'd0, 2, 5);
    pulse_start(2'd0);
    step(2);
    check("c0_pre_rst", 32'(running), 32'h1);
    #3 reset = 1'b1;
    #1;
    check_hms("arst", 0, 0, 0);
    check("arst_run", 32'(running), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_any", 32'(any_done), 32'h0);
    ch_sel = 2'd1; #1;
    check("arst_c1_s", 32'(sel_seconds), 32'd0);
    @(posedge clk_1Hz); #2;
    reset = 1'b0;
    step(5);
    check("post_rst_pulse", 32'(done_pulse), 32'h0);
    check("post_rst_done", 32'(done), 32'h0);

    // Expiry with autoreload requested
    inc_field(2'd0, 2, 2);
    autoreload = 1'b1;
    pulse_start(2'd0);
    autoreload = 1'b0;
    step(1);
    check("ar_e1_s", 32'(sel_seconds), 32'd1);
    step(1);
    check("ar_e2_pulse", 32'(done_pulse), 32'h1);
    check("ar_e2_done", 32'(done), 32'h1);
`ifdef TIMER_AUTORELOAD_EN
    check("ar_e2_run", 32'(running), 32'h1);
    check("ar_e2_s", 32'(sel_seconds), 32'd2);
    step(1);
    check("ar_e3_pulse", 32'(done_pulse), 32'h0);
    step(1);
    check("ar_e4_pulse", 32'(done_pulse), 32'h1);
    check("ar_e4_run", 32'(running), 32'h1);
`else
    check("noar_e2_run", 32'(running), 32'h0);
    check("noar_e2_s", 32'(sel_seconds), 32'd0);
    step(1);
    check("noar_e3_pulse", 32'(done_pulse), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
